// File: rtl/audio_sample_fifo_pkg.sv
// Shared constants for the Wishbone-fed stereo sample FIFO in front of spdif_tx:
// register map, CSR bit positions, pop FSM encoding and the output attenuation helper.
package audio_sample_fifo_pkg;

    localparam logic [1:0] REG_CSR    = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_LEVEL  = 2'd2;
    localparam logic [1:0] REG_THRESH = 2'd3;

    localparam int CSR_ENABLE   = 0;
    localparam int CSR_FLUSH    = 1;
    localparam int CSR_UNDERRUN = 2;
    localparam int CSR_OVERFLOW = 3;
    localparam int CSR_EMPTY    = 4;
    localparam int CSR_FULL     = 5;
    localparam int CSR_IRQ      = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;

    // 16-bit sample placed in the top of a 24-bit word, then scaled down for headroom
    function automatic logic [23:0] attenuate(input logic [15:0] sample, input int shift);
        logic signed [23:0] v;
        v = $signed({sample, 8'h00});
        return v >>> shift;
    endfunction

endpackage

// File: rtl/audio_fifo_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// No reset on the array or read register so it maps onto iCE40 block RAM.
module audio_fifo_ram #(
    parameter int LOG2_DEPTH = 8,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [LOG2_DEPTH-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_re,
    input  logic [LOG2_DEPTH-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);

    logic [WIDTH-1:0] r_mem [(1 << LOG2_DEPTH)];

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        if (i_re)
            o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/audio_sample_fifo_wb.sv
// Wishbone-writable stereo sample FIFO feeding the S/PDIF encoder, one pop per encoder ack.
// Define AUDIO_SAMPLE_FIFO_IRQ_EN to add the THRESH register and the level irq output.
module audio_sample_fifo_wb
    import audio_sample_fifo_pkg::*;
#(
    parameter int LOG2_DEPTH = 8,
    parameter int ATTEN      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  wb_addr,
    input  logic [31:0] wb_wdata,
    output logic [31:0] wb_rdata,
    input  logic        wb_we,
    input  logic        wb_cyc,
    output logic        wb_ack,
    output logic [23:0] audio_l,
    output logic [23:0] audio_r,
    output logic        valid,
`ifdef AUDIO_SAMPLE_FIFO_IRQ_EN
    output logic        irq,
`endif
    input  logic        ack
);

    localparam int PW = LOG2_DEPTH + 1;

    logic          r_wb_ack;
    logic          r_enable;
    logic          r_underrun;
    logic          r_overflow;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [1:0]    r_state;
    logic [15:0]   r_hold_l;
    logic [15:0]   r_hold_r;

    logic          w_wr;
    logic          w_csr_wr;
    logic          w_flush;
    logic          w_push_req;
    logic          w_push;
    logic          w_drop;
    logic          w_pop;
    logic          w_underrun;
    logic          w_empty;
    logic          w_full;
    logic [PW-1:0] w_level;
    logic [31:0]   w_rdata;
    logic [31:0]   w_reg_rd;
    logic          w_irq;
    logic          w_unused;

    assign w_unused = ^wb_addr[3:2];

    // Writes take effect on the edge that ends the ack cycle
    assign w_wr       = wb_cyc & r_wb_ack & wb_we;
    assign w_csr_wr   = w_wr & (wb_addr[1:0] == REG_CSR);
    assign w_flush    = w_csr_wr & wb_wdata[CSR_FLUSH];
    assign w_push_req = w_wr & (wb_addr[1:0] == REG_DATA);

    assign w_level = r_wptr - r_rptr;
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = ((r_wptr ^ r_rptr) == {1'b1, {LOG2_DEPTH{1'b0}}});

    assign w_pop      = (r_state == ST_IDLE) & ack & r_enable & ~w_empty & ~w_flush;
    assign w_underrun = (r_state == ST_IDLE) & ack & r_enable &  w_empty & ~w_flush;
    // A pop in the same cycle frees a slot, so a push to a full FIFO still lands
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & ~w_push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_wb_ack <= 1'b0;
        else
            r_wb_ack <= wb_cyc & ~r_wb_ack;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (w_flush) begin
            r_rptr <= r_wptr;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable   <= 1'b0;
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_csr_wr)
                r_enable <= wb_wdata[CSR_ENABLE];
            r_underrun <= w_underrun | (r_underrun & ~(w_csr_wr & wb_wdata[CSR_UNDERRUN]));
            r_overflow <= w_drop     | (r_overflow & ~(w_csr_wr & wb_wdata[CSR_OVERFLOW]));
        end
    end

    // Flush and disable both abort any pop in flight and silence the output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_hold_l <= '0;
            r_hold_r <= '0;
        end else if (w_flush || !r_enable) begin
            r_state  <= ST_IDLE;
            r_hold_l <= '0;
            r_hold_r <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_state <= ST_READ;
                    end else if (w_underrun) begin
                        r_hold_l <= '0;
                        r_hold_r <= '0;
                    end
                end
                ST_READ: r_state <= ST_LOAD;
                ST_LOAD: begin
                    r_hold_l <= w_rdata[31:16];
                    r_hold_r <= w_rdata[15:0];
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    audio_fifo_ram #(
        .LOG2_DEPTH (LOG2_DEPTH),
        .WIDTH      (32)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wptr[LOG2_DEPTH-1:0]),
        .i_wdata (wb_wdata),
        .i_re    (w_pop),
        .i_raddr (r_rptr[LOG2_DEPTH-1:0]),
        .o_rdata (w_rdata)
    );

`ifdef AUDIO_SAMPLE_FIFO_IRQ_EN
    logic [PW-1:0] r_thresh;
    logic          r_irq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_thresh <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr && wb_addr[1:0] == REG_THRESH)
                r_thresh <= wb_wdata[PW-1:0];
            r_irq <= r_enable & (w_level <= r_thresh);
        end
    end

    assign irq   = r_irq;
    assign w_irq = r_irq;
`else
    assign w_irq = 1'b0;
`endif

    always_comb begin
        w_reg_rd = '0;
        case (wb_addr[1:0])
            REG_CSR: begin
                w_reg_rd[CSR_ENABLE]   = r_enable;
                w_reg_rd[CSR_UNDERRUN] = r_underrun;
                w_reg_rd[CSR_OVERFLOW] = r_overflow;
                w_reg_rd[CSR_EMPTY]    = w_empty;
                w_reg_rd[CSR_FULL]     = w_full;
                w_reg_rd[CSR_IRQ]      = w_irq;
            end
            REG_LEVEL: w_reg_rd[PW-1:0] = w_level;
`ifdef AUDIO_SAMPLE_FIFO_IRQ_EN
            REG_THRESH: w_reg_rd[PW-1:0] = r_thresh;
`endif
            default: w_reg_rd = '0;
        endcase
    end

    assign wb_ack   = r_wb_ack;
    assign wb_rdata = (r_wb_ack & ~wb_we) ? w_reg_rd : 32'h0;
    assign audio_l  = attenuate(r_hold_l, ATTEN);
    assign audio_r  = attenuate(r_hold_r, ATTEN);
    assign valid    = r_enable;

endmodule

// File: tb/tb_audio_sample_fifo_wb.sv
// Randomized bench for audio_sample_fifo_wb against a queue-based model of the FIFO and CSR.
module tb_audio_sample_fifo_wb;

    localparam int LOG2_DEPTH = 8;
    localparam int DEPTH      = 1 << LOG2_DEPTH;
    localparam int ATTEN      = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  wb_addr;
    logic [31:0] wb_wdata;
    logic [31:0] wb_rdata;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_ack;
    logic [23:0] audio_l;
    logic [23:0] audio_r;
    logic        valid;
    logic        ack;
`ifdef AUDIO_SAMPLE_FIFO_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    audio_sample_fifo_wb #(
        .LOG2_DEPTH (LOG2_DEPTH),
        .ATTEN      (ATTEN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_addr  (wb_addr),
        .wb_wdata (wb_wdata),
        .wb_rdata (wb_rdata),
        .wb_we    (wb_we),
        .wb_cyc   (wb_cyc),
        .wb_ack   (wb_ack),
        .audio_l  (audio_l),
        .audio_r  (audio_r),
        .valid    (valid),
`ifdef AUDIO_SAMPLE_FIFO_IRQ_EN
        .irq      (irq),
`endif
        .ack      (ack)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model
    logic [31:0] q[$];
    bit          m_en, m_und, m_ovf;
    logic [15:0] m_hl, m_hr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] exp_audio(input logic [15:0] h);
        int v;
        v = int'($signed(h)) * (256 >> ATTEN);
        return 24'(v);
    endfunction

    function automatic logic [31:0] exp_csr();
        logic [31:0] c;
        c = '0;
        c[0] = m_en;
        c[2] = m_und;
        c[3] = m_ovf;
        c[4] = (q.size() == 0);
        c[5] = (q.size() == DEPTH);
        return c;
    endfunction

    task automatic model_reset();
        q.delete();
        m_en = 0; m_und = 0; m_ovf = 0;
        m_hl = '0; m_hr = '0;
    endtask

    task automatic model_csr(input logic [31:0] d);
        m_en = d[0];
        if (d[1]) begin
            q.delete();
            m_hl = '0; m_hr = '0;
        end
        if (d[2]) m_und = 0;
        if (d[3]) m_ovf = 0;
        if (!m_en) begin
            m_hl = '0; m_hr = '0;
        end
    endtask

    task automatic wb_xfer(input logic [3:0] a, input logic we, input logic [31:0] d,
                           output logic [31:0] rd);
        int n;
        @(negedge clk);
        wb_addr = a; wb_we = we; wb_wdata = d; wb_cyc = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!wb_ack && n < 8);
        if (!wb_ack) chk("wb_ack_timeout", {31'b0, wb_ack}, 32'd1);
        rd = wb_rdata;
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_we = 1'b0;
    endtask

    task automatic do_csr(input logic [31:0] d);
        logic [31:0] dummy;
        wb_xfer(4'd0, 1'b1, d, dummy);
        model_csr(d);
    endtask

    task automatic do_push(input logic [31:0] d);
        logic [31:0] dummy;
        wb_xfer(4'd1, 1'b1, d, dummy);
        if (q.size() < DEPTH) q.push_back(d);
        else m_ovf = 1;
    endtask

    task automatic do_ack(input string tag);
        logic [31:0] w;
        @(negedge clk); ack = 1'b1;
        @(negedge clk); ack = 1'b0;
        repeat (4) @(negedge clk);
        if (m_en) begin
            if (q.size() > 0) begin
                w = q.pop_front();
                m_hl = w[31:16]; m_hr = w[15:0];
            end else begin
                m_hl = '0; m_hr = '0; m_und = 1;
            end
        end
        chk({tag, "_audio_l"}, {8'h0, audio_l}, {8'h0, exp_audio(m_hl)});
        chk({tag, "_audio_r"}, {8'h0, audio_r}, {8'h0, exp_audio(m_hr)});
    endtask

    task automatic chk_regs(input string tag);
        logic [31:0] rd;
        wb_xfer(4'd0, 1'b0, 32'h0, rd);
`ifdef AUDIO_SAMPLE_FIFO_IRQ_EN
        rd[6] = 1'b0;
`endif
        chk({tag, "_csr"}, rd, exp_csr());
        wb_xfer(4'd2, 1'b0, 32'h0, rd);
        chk({tag, "_level"}, rd, q.size());
        chk({tag, "_valid"}, {31'b0, valid}, {31'b0, m_en});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, d;
        int op;
        rst_n = 1'b0; wb_addr = '0; wb_wdata = '0; wb_we = 1'b0; wb_cyc = 1'b0; ack = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        chk("rst_audio_l", {8'h0, audio_l}, 32'h0);
        chk("rst_audio_r", {8'h0, audio_r}, 32'h0);
        chk("rst_wb_ack", {31'b0, wb_ack}, 32'h0);
        chk_regs("rst");

        // Two known samples through the attenuator
        do_csr(32'h1);
        do_push(32'h4000_0001);
        do_push(32'hC000_FFFF);
        chk_regs("two");
        do_ack("pop1");
        chk("pop1_l_const", {8'h0, audio_l}, 32'h0010_0000);
        chk("pop1_r_const", {8'h0, audio_r}, 32'h0000_0040);
        do_ack("pop2");
        chk("pop2_l_const", {8'h0, audio_l}, 32'h00F0_0000);
        chk("pop2_r_const", {8'h0, audio_r}, 32'h00FF_FFC0);
        chk_regs("drained");

        // Underrun and its write-1-clear
        do_ack("under");
        chk_regs("under");
        do_csr(32'h5);
        chk_regs("under_clr");

        // Overfill: 257th word dropped, then drain everything
        for (int i = 0; i <= DEPTH; i++) do_push($urandom);
        chk_regs("full");
        for (int i = 0; i < DEPTH; i++) do_ack("drain");
        chk_regs("after_drain");
        do_csr(32'hD);

        // Random mix of traffic
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                do_push($urandom);
            end else if (op <= 6) begin
                do_ack("rnd");
            end else if (op == 7) begin
                chk_regs("rnd");
            end else if (op == 8) begin
                d = '0;
                d[0] = ($urandom_range(0, 3) != 0);
                d[1] = ($urandom_range(0, 7) == 0);
                d[3:2] = 2'($urandom_range(0, 3));
                do_csr(d);
            end else begin
                wb_xfer(4'd1, 1'b0, 32'h0, rd);
                chk("rnd_data_rd", rd, 32'h0);
`ifndef AUDIO_SAMPLE_FIFO_IRQ_EN
                wb_xfer(4'd3, 1'b0, 32'h0, rd);
                chk("rnd_rsvd_rd", rd, 32'h0);
`endif
            end
        end

        // Flush lands while the pop is in READ
        do_csr(32'hD);
        do_push(32'h1234_5678);
        for (int i = 0; i < 9; i++) do_push($urandom);
        do_ack("pre_flush");
        @(negedge clk);
        ack = 1'b1; wb_cyc = 1'b1; wb_we = 1'b1; wb_addr = 4'd0; wb_wdata = 32'h3;
        @(posedge clk); #1;
        ack = 1'b0;
        chk("flush_wb_ack", {31'b0, wb_ack}, 32'd1);
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_we = 1'b0;
        model_csr(32'h3);
        repeat (4) @(negedge clk);
        chk("flush_audio_l", {8'h0, audio_l}, 32'h0);
        chk("flush_audio_r", {8'h0, audio_r}, 32'h0);
        chk_regs("flush");

        // Asynchronous reset in the middle of LOAD
        do_push(32'h7FFF_8000);
        do_push(32'h0100_0200);
        do_ack("pre_rst");
        @(negedge clk); ack = 1'b1;
        @(posedge clk); #1 ack = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_audio_l", {8'h0, audio_l}, 32'h0);
        chk("arst_audio_r", {8'h0, audio_r}, 32'h0);
        chk("arst_valid", {31'b0, valid}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        chk_regs("arst");

`ifdef AUDIO_SAMPLE_FIFO_IRQ_EN
        do_csr(32'h1);
        wb_xfer(4'd3, 1'b1, 32'd4, rd);
        for (int i = 0; i < 5; i++) do_push($urandom);
        repeat (2) @(negedge clk);
        chk("irq_lvl5", {31'b0, irq}, 32'd0);
        do_ack("irq");
        chk("irq_lvl4", {31'b0, irq}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/audio_sample_fifo_wb.md
Name: audio_sample_fifo_wb

Overview:
Wishbone-writable stereo sample FIFO that feeds the S/PDIF encoder. It replaces the free-running test waveform in front of spdif_tx. Host software pushes packed {L,R} 16-bit samples over the USB-Wishbone bridge. The block pops one sample per encoder ack and reports level, underrun and overflow status.

Parameters:
- LOG2_DEPTH, 8: FIFO depth is 2^LOG2_DEPTH stereo words (default 256).
- ATTEN, 2: right-shift applied to each sample on output (volume headroom); range 0..7.

Ports:
- clk  in  1  system clock (clk_1x domain).
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- wb_addr  in  4  word address (only [1:0] decoded).
- wb_wdata  in  32  write data.
- wb_rdata  out  32  read data; zero when not acking.
- wb_we  in  1  write enable.
- wb_cyc  in  1  cycle/select.
- wb_ack  out  1  single-cycle acknowledge.
- audio_l  out  24  left sample to encoder.
- audio_r  out  24  right sample to encoder.
- valid  out  1  sample-valid flag to encoder.
- ack  in  1  encoder consumed current sample (1-cycle pulse).

Behaviour:
- Wishbone:
  - wb_ack <= wb_cyc & ~wb_ack, so the ack comes 1 cycle after cyc and back-to-back cycles ack every 2nd clock.
  - Side effects occur only on the cycle wb_ack is asserted.
- Registers (word addr):
  - 0 CSR:
    - bit0 ENABLE (rw).
    - bit1 FLUSH (write-1 pulse, reads 0).
    - bit2 UNDERRUN sticky (write-1-clear).
    - bit3 OVERFLOW sticky (W1C).
    - bit4 EMPTY (ro).
    - bit5 FULL (ro).
  - 1 DATA (wo): wdata[31:16]=L, [15:0]=R, pushed into FIFO. Reads return 0.
  - 2 LEVEL (ro): [LOG2_DEPTH:0] = current occupancy 0..2^LOG2_DEPTH.
  - 3 reserved: reads 0, writes ignored.
- FIFO:
  - Inferred synchronous RAM with read/write pointers LOG2_DEPTH+1 bits wide (MSB wrap bit).
  - Full when pointers differ only in MSB; empty when equal.
  - Push to full FIFO is dropped, sets OVERFLOW, and leaves the level unchanged.
  - Simultaneous push and pop in the same cycle: both happen, level unchanged. This includes push while full when a pop occurs the same cycle: the push is accepted.
- Output holding register:
  - {hold_l, hold_r}, 16 bits each.
  - audio_x = sign-extended {hold_x, 8'h00} arithmetically shifted right by ATTEN, 24-bit result.
- Pop state machine, states IDLE, READ, LOAD:
  - IDLE: on ack with ENABLE=1:
    - FIFO non-empty: issue RAM read, go to READ.
    - Empty: load hold=0, set UNDERRUN, stay in IDLE.
  - READ: RAM data valid, go to LOAD.
  - LOAD: hold <= RAM data, go to IDLE.
  - Worst-case pop latency: hold updated 2 cycles after ack. The encoder acks at most once per ~500 clocks.
  - ENABLE=0: ack is ignored, hold is forced to 0, no underrun is flagged.
- valid = ENABLE.
- FLUSH:
  - Pointers are set equal (level 0) and hold <= 0.
  - The pop FSM returns to IDLE; an in-flight READ/LOAD is aborted.
  - FLUSH takes priority over a same-cycle ack.
  - ENABLE and the sticky bits are unchanged.
- Reset values:
  - wb_ack=0, wb_rdata=0.
  - ENABLE=0, sticky bits=0, pointers=0, hold=0.
  - audio_l=audio_r=0, valid=0, FSM=IDLE.
- Reset asserted mid-transfer clears all state immediately; the RAM contents are don't-care.

Optional Feature:
- Macro AUDIO_SAMPLE_FIFO_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit) and register 3 THRESH (rw, [LOG2_DEPTH:0], reset 0).
  - irq is registered and equals ENABLE & (level <= THRESH).
  - CSR bit6 IRQ (ro) mirrors irq.
- Undefined:
  - No irq port.
  - Register 3 reads 0 and ignores writes.
  - CSR bit6 reads 0.

Decomposition:
- Shared package (audio_sample_fifo_pkg) holds:
  - Register addresses: CSR=0, DATA=1, LEVEL=2, THRESH=3.
  - CSR bit indices.
  - FSM state encoding constants.
- One natural sub-module: audio_fifo_ram.
  - Parameterised synchronous 32-bit x 2^LOG2_DEPTH RAM, 1 write and 1 registered read port.
  - Maps to SB_RAM40_4K on iCE40.
  - Pointer/flag logic stays in the top of the block.

Test Plan:
- Reset, CSR read: CSR returns 0x10 (EMPTY), LEVEL returns 0; audio_l/audio_r=0, valid=0.
- Enable, write DATA 0x40000001 then 0xC000FFFF, LEVEL=2, pulse ack twice (≥3 cycles apart), ATTEN=2:
  - First pop: audio_l=0x100000, audio_r=0x000040.
  - Second pop: audio_l=0xF00000, audio_r=0xFFFFC0.
  - LEVEL returns 0.
- ack with FIFO empty and ENABLE=1: hold=0, CSR bit2 set; writing CSR=0x5 clears bit2 and keeps ENABLE.
- Write 257 DATA words with depth 256, no acks: LEVEL=256, FULL=1, OVERFLOW=1; the 257th word is never output.
- Fill 10 words, ack, then FLUSH on the next cycle (during READ): LEVEL=0, hold=0, FSM IDLE, no pop committed.
- Assert rst_n low asynchronously between clock edges mid-LOAD: all outputs go to 0 immediately without waiting for a clock edge.
- With AUDIO_SAMPLE_FIFO_IRQ_EN, THRESH=4, level dropping 5→4 via ack: irq rises 1 cycle after LEVEL reads 4.
